// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and constants for the up/down sequencer
// Purpose: FSM state type, value range limits, display mode encodings and a
//          helper that sizes the repeat timer.
// Ports:   none (package)
package display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } seq_state_t;

   localparam logic [15:0] DEC_MAX  = 16'd9999;
   localparam logic [15:0] HEX_MAX  = 16'hFFFF;

   localparam logic        MODE_DEC = 1'b0;
   localparam logic        MODE_HEX = 1'b1;

   // Counter width able to hold max(a,b)-1, never less than one bit.
   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 3) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/repeat_timer.sv
// rtl/repeat_timer.sv - loadable down-counter pacing hold and auto-repeat steps
// Purpose: counts down from a loaded value and flags expiry at zero.
// Ports:   clk, rst_n        - clock, synchronous active-low reset
//          i_clear           - force count to zero
//          i_load/i_load_val - load a new count (clear wins)
//          o_expire          - high while the count is zero
module repeat_timer
   import display_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clear,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_expire
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_expire = (r_count == '0);

endmodule

// File: rtl/updown_sequencer.sv
// rtl/updown_sequencer.sv - button-driven step/auto-repeat controller for f
// Purpose: turns level buttons into single and auto-repeat steps on a 16-bit
//          value with decimal (0..9999) or hex (0..FFFF) wrap rules.
// Ports:   clk, rst_n              - clock, synchronous active-low reset
//          btn_inc, btn_dec        - step buttons (level, debounced)
//          btn_mode                - decimal/hex toggle on rising edge
//          btn_clr                 - clear f while high
//          f, displayMode          - registered value and mode (1 = hex)
//          wrap                    - one-cycle pulse with a wrapped f
module updown_sequencer
   import display_pkg::*;
#(
   parameter int REPEAT_DELAY = 25_000_000,
   parameter int REPEAT_RATE  = 5_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_inc,
   input  logic        btn_dec,
   input  logic        btn_mode,
   input  logic        btn_clr,
   output logic [15:0] f,
   output logic        displayMode,
   output logic        wrap
);

   localparam int TW = timer_width(REPEAT_DELAY, REPEAT_RATE);
   localparam logic [TW-1:0] DELAY_LOAD = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] RATE_LOAD  = TW'(REPEAT_RATE - 1);

   seq_state_t     r_state;
   logic [15:0]    r_f;
   logic           r_mode;
   logic           r_wrap;
   logic           r_dir_up;
   logic           r_inc_q;
   logic           r_dec_q;
   logic           r_mode_q;

   seq_state_t     w_next_state;
   logic           w_up;
   logic           w_dn;
   logic           w_keep;
   logic           w_rise_inc;
   logic           w_rise_dec;
   logic           w_rise_mode;
   logic           w_step;
   logic           w_step_up;
   logic           w_next_dir_up;
   logic           w_tmr_clr;
   logic           w_tmr_load;
   logic [TW-1:0]  w_load_val;
   logic           w_expire;
   logic [15:0]    w_max;
   logic           w_at_edge;
   logic [15:0]    w_f_step;

   repeat_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clear    (w_tmr_clr),
      .i_load     (w_tmr_load),
      .i_load_val (w_load_val),
      .o_expire   (w_expire)
   );

   always_comb begin
      w_up          = btn_inc & ~btn_dec;
      w_dn          = btn_dec & ~btn_inc;
      w_rise_inc    = btn_inc & ~r_inc_q;
      w_rise_dec    = btn_dec & ~r_dec_q;
      w_rise_mode   = btn_mode & ~r_mode_q;
      // Holding continues only while the original direction is still the sole one.
      w_keep        = r_dir_up ? w_up : w_dn;
      w_step        = 1'b0;
      w_step_up     = r_dir_up;
      w_next_dir_up = r_dir_up;
      w_next_state  = r_state;
      w_tmr_clr     = 1'b0;
      w_tmr_load    = 1'b0;
      w_load_val    = DELAY_LOAD;

      case (r_state)
         ST_IDLE: begin
            if ((w_up & w_rise_inc) | (w_dn & w_rise_dec)) begin
               w_step        = 1'b1;
               w_step_up     = w_up;
               w_next_dir_up = w_up;
               w_next_state  = ST_HOLD;
               w_tmr_load    = 1'b1;
               w_load_val    = DELAY_LOAD;
            end
         end
         ST_HOLD, ST_REPEAT: begin
            if (!w_keep) begin
               w_next_state = ST_IDLE;
               w_tmr_clr    = 1'b1;
            end else if (w_expire) begin
               w_step       = 1'b1;
               w_next_state = ST_REPEAT;
               w_tmr_load   = 1'b1;
               w_load_val   = RATE_LOAD;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
            w_tmr_clr    = 1'b1;
         end
      endcase

      if (btn_clr) begin
         w_step       = 1'b0;
         w_next_state = ST_IDLE;
         w_tmr_clr    = 1'b1;
         w_tmr_load   = 1'b0;
      end

      w_max = (r_mode == MODE_HEX) ? HEX_MAX : DEC_MAX;
      if (w_step_up) begin
         w_at_edge = (r_f == w_max);
         w_f_step  = w_at_edge ? 16'd0 : r_f + 16'd1;
      end else begin
         w_at_edge = (r_f == 16'd0);
         w_f_step  = w_at_edge ? w_max : r_f - 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_f      <= '0;
         r_mode   <= MODE_DEC;
         r_wrap   <= 1'b0;
         r_dir_up <= 1'b0;
         r_inc_q  <= 1'b0;
         r_dec_q  <= 1'b0;
         r_mode_q <= 1'b0;
      end else begin
         r_inc_q  <= btn_inc;
         r_dec_q  <= btn_dec;
         r_mode_q <= btn_mode;
         r_state  <= w_next_state;
         r_dir_up <= w_next_dir_up;
         r_wrap   <= 1'b0;
         if (btn_clr) begin
            r_f <= '0;
         end else if (w_rise_mode) begin
            // A mode edge swallows any step due this cycle; FSM timing is unaffected.
            r_mode <= ~r_mode;
            if (r_mode == MODE_HEX && r_f > DEC_MAX) begin
               r_f <= DEC_MAX;
            end
         end else if (w_step) begin
            r_f    <= w_f_step;
            r_wrap <= w_at_edge;
         end
      end
   end

   assign f           = r_f;
   assign displayMode = r_mode;
   assign wrap        = r_wrap;

endmodule
